// File: rtl/half_array_collector_pkg.sv
// Shared constants, kind encoding and FSM state for the half-sample array collector
// and the input row/column mux that reads the arrays back.
package half_array_collector_pkg;

   localparam int unsigned NUM_PIXEL = 8;
   localparam int unsigned LANES     = 15;
   localparam int unsigned IN_W      = 16;
   localparam int unsigned SHIFT     = 6;
   localparam int unsigned SAMPLE_W  = 8;
   localparam int unsigned ROW_IDX_W = 3;
   localparam int unsigned NUM_KINDS = 3;
   localparam int unsigned ROW_W     = LANES * SAMPLE_W;
   localparam int unsigned ARRAY_W   = NUM_PIXEL * ROW_W;
   localparam int unsigned MAP_W     = NUM_KINDS * NUM_PIXEL;

   typedef logic [1:0] kind_t;

   localparam kind_t KIND_A       = 2'd0;
   localparam kind_t KIND_B       = 2'd1;
   localparam kind_t KIND_C       = 2'd2;
   localparam kind_t KIND_DISCARD = 2'd3;

   typedef enum logic [1:0] {
      StCollect,
      StDrain,
      StFull
   } state_e;

   typedef logic [NUM_PIXEL-1:0][ROW_W-1:0] half_arr_t;

   // One-hot bitmap bit for a (kind,row) pair; zero for anything that must not be written.
   function automatic logic [MAP_W-1:0] row_mask(kind_t kind, logic [ROW_IDX_W-1:0] row);
      logic [MAP_W-1:0] mask;
      mask = '0;
      if (kind != KIND_DISCARD && int'(row) < int'(NUM_PIXEL)) begin
         mask = MAP_W'(1) << (int'(kind) * int'(NUM_PIXEL) + int'(row));
      end
      return mask;
   endfunction

endpackage

// File: rtl/half_array_collector_if.sv
// Row-write and array-read handshake bundle of the collector.
// Carries dup_err only when HALF_COLLECT_DUP_ERR_EN is defined.
interface half_array_collector_if;
   import half_array_collector_pkg::*;

   logic                       in_valid;
   logic                       in_ready;
   kind_t                      in_kind;
   logic [ROW_IDX_W-1:0]       in_row;
   logic [LANES*IN_W-1:0]      in_data;
   logic [ARRAY_W-1:0]         a_half_array;
   logic [ARRAY_W-1:0]         b_half_array;
   logic [ARRAY_W-1:0]         c_half_array;
   logic                       out_valid;
   logic                       out_ready;

`ifdef HALF_COLLECT_DUP_ERR_EN
   logic                       dup_err;

   modport master (
      output in_valid, in_kind, in_row, in_data, out_ready,
      input  in_ready, a_half_array, b_half_array, c_half_array, out_valid, dup_err
   );
   modport slave (
      input  in_valid, in_kind, in_row, in_data, out_ready,
      output in_ready, a_half_array, b_half_array, c_half_array, out_valid, dup_err
   );
`else
   modport master (
      output in_valid, in_kind, in_row, in_data, out_ready,
      input  in_ready, a_half_array, b_half_array, c_half_array, out_valid
   );
   modport slave (
      input  in_valid, in_kind, in_row, in_data, out_ready,
      output in_ready, a_half_array, b_half_array, c_half_array, out_valid
   );
`endif

endinterface

// File: rtl/half_round_clip.sv
// Per-lane round, arithmetic right shift and clip of one signed filter output to an
// unsigned sample.
module half_round_clip #(
   parameter int unsigned InW   = 16,
   parameter int unsigned Shift = 6,
   parameter int unsigned OutW  = 8
) (
   input  logic [InW-1:0]  x_i,
   output logic [OutW-1:0] y_o
);

   logic signed [InW:0] sum;
   logic signed [InW:0] shifted;

   // One guard bit keeps the rounding add from wrapping near the positive limit.
   assign sum     = $signed({x_i[InW-1], x_i}) + $signed((InW+1)'(1) << (Shift - 1));
   assign shifted = sum >>> Shift;

   always_comb begin
      if (shifted[InW]) begin
         y_o = '0;
      end else if (|shifted[InW-1:OutW]) begin
         y_o = '1;
      end else begin
         y_o = shifted[OutW-1:0];
      end
   end

endmodule

// File: rtl/half_array_collector.sv
// Packs rounded/clipped filter rows into the A/B/C half arrays and hands them out once
// every row is present. Optional dup_err flag: define HALF_COLLECT_DUP_ERR_EN.
module half_array_collector
   import half_array_collector_pkg::*;
(
   input logic                   clock,
   input logic                   reset,
   half_array_collector_if.slave bus
);

   logic [ROW_W-1:0] clip_row;

   for (genvar i = 0; i < LANES; i++) begin : g_lane
      half_round_clip #(
         .InW   (IN_W),
         .Shift (SHIFT),
         .OutW  (SAMPLE_W)
      ) u_clip (
         .x_i (bus.in_data[i*IN_W +: IN_W]),
         .y_o (clip_row[i*SAMPLE_W +: SAMPLE_W])
      );
   end

   state_e                 state_q, state_d;
   logic                   in_ready_q, in_ready_d;
   logic                   out_valid_q, out_valid_d;
   logic                   s1_valid_q, s1_valid_d;
   kind_t                  s1_kind_q, s1_kind_d;
   logic [ROW_IDX_W-1:0]   s1_row_q, s1_row_d;
   logic [MAP_W-1:0]       s1_mask_q, s1_mask_d;
   logic [ROW_W-1:0]       s1_data_q, s1_data_d;
   logic [MAP_W-1:0]       written_q, written_d;
   half_arr_t              a_q, a_d, b_q, b_d, c_q, c_d;
`ifdef HALF_COLLECT_DUP_ERR_EN
   logic                   dup_err_q, dup_err_d;
`endif

   logic             accept;
   logic [MAP_W-1:0] in_mask;
   logic             completes;
   logic             s2_wr;
   logic             out_hs;

   assign accept  = bus.in_valid & in_ready_q;
   assign in_mask = row_mask(bus.in_kind, bus.in_row);
   // The stage-1 row is not in the bitmap yet, so it has to be counted here.
   assign completes = accept & (&(written_q | s1_mask_q | in_mask));
   assign s2_wr     = s1_valid_q & (|s1_mask_q);
   assign out_hs    = out_valid_q & bus.out_ready;

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StCollect: if (completes) state_d = StDrain;
         StDrain:   state_d = StFull;
         StFull:    if (out_hs) state_d = StCollect;
         default:   state_d = StCollect;
      endcase
      in_ready_d  = (state_d == StCollect);
      out_valid_d = (state_d == StFull);

      s1_valid_d = accept;
      s1_mask_d  = accept ? in_mask : '0;
      s1_kind_d  = accept ? bus.in_kind : s1_kind_q;
      s1_row_d   = accept ? bus.in_row : s1_row_q;
      s1_data_d  = accept ? clip_row : s1_data_q;

      a_d = a_q;
      b_d = b_q;
      c_d = c_q;
      written_d = written_q;
      if (s2_wr) begin
         case (s1_kind_q)
            KIND_A:  a_d[s1_row_q] = s1_data_q;
            KIND_B:  b_d[s1_row_q] = s1_data_q;
            KIND_C:  c_d[s1_row_q] = s1_data_q;
            default: ;
         endcase
         written_d = written_q | s1_mask_q;
      end
      if (out_hs) written_d = '0;

`ifdef HALF_COLLECT_DUP_ERR_EN
      dup_err_d = dup_err_q;
      if (s2_wr && |(written_q & s1_mask_q)) dup_err_d = 1'b1;
      if (out_hs) dup_err_d = 1'b0;
`endif
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= StCollect;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         s1_valid_q  <= 1'b0;
         s1_kind_q   <= KIND_A;
         s1_row_q    <= '0;
         s1_mask_q   <= '0;
         s1_data_q   <= '0;
         written_q   <= '0;
         a_q         <= '0;
         b_q         <= '0;
         c_q         <= '0;
`ifdef HALF_COLLECT_DUP_ERR_EN
         dup_err_q   <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         s1_valid_q  <= s1_valid_d;
         s1_kind_q   <= s1_kind_d;
         s1_row_q    <= s1_row_d;
         s1_mask_q   <= s1_mask_d;
         s1_data_q   <= s1_data_d;
         written_q   <= written_d;
         a_q         <= a_d;
         b_q         <= b_d;
         c_q         <= c_d;
`ifdef HALF_COLLECT_DUP_ERR_EN
         dup_err_q   <= dup_err_d;
`endif
      end
   end

   assign bus.in_ready     = in_ready_q;
   assign bus.out_valid    = out_valid_q;
   assign bus.a_half_array = a_q;
   assign bus.b_half_array = b_q;
   assign bus.c_half_array = c_q;
`ifdef HALF_COLLECT_DUP_ERR_EN
   assign bus.dup_err      = dup_err_q;
`endif

endmodule

// File: tb/tb_half_array_collector.sv
// Scoreboard bench for half_array_collector: random rows drive a byte-level reference
// model; a monitor compares the arrays each time out_valid rises.
module tb_half_array_collector;
   import half_array_collector_pkg::*;

   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   half_array_collector_if bus();

   half_array_collector dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(string name, logic [ARRAY_W-1:0] act, logic [ARRAY_W-1:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic check1(string name, logic act, logic exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0b expected %0b", name, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   logic [7:0]         mdl_mem [3][NUM_PIXEL][LANES];
   bit                 mdl_done [3][NUM_PIXEL];
   bit                 mdl_dup;
   logic [ARRAY_W-1:0] exp_a_q[$], exp_b_q[$], exp_c_q[$];
   bit                 exp_dup_q[$];
   int                 accept_cnt = 0;
   int                 lane_v[LANES];
   int                 ord_q[$];

   // Round half up then floor-divide by 64, saturated to a byte.
   function automatic logic [7:0] ref_clip(int x);
      int q;
      q = x + 32;
      if (q < 0) q = -((-q + 63) / 64);
      else q = q / 64;
      if (q < 0) return 8'd0;
      if (q > 255) return 8'd255;
      return q[7:0];
   endfunction

   function automatic logic [ARRAY_W-1:0] mdl_pack(int k);
      logic [ARRAY_W-1:0] v;
      v = '0;
      for (int r = 0; r < NUM_PIXEL; r++)
         for (int i = 0; i < LANES; i++) v[(r*LANES+i)*8 +: 8] = mdl_mem[k][r][i];
      return v;
   endfunction

   task automatic mdl_reset();
      for (int k = 0; k < 3; k++)
         for (int r = 0; r < NUM_PIXEL; r++) begin
            mdl_done[k][r] = 1'b0;
            for (int i = 0; i < LANES; i++) mdl_mem[k][r][i] = 8'd0;
         end
      mdl_dup = 1'b0;
   endtask

   task automatic mdl_accept(int kind, int row);
      bit all;
      if (kind < 3 && row < NUM_PIXEL) begin
         if (mdl_done[kind][row]) mdl_dup = 1'b1;
         mdl_done[kind][row] = 1'b1;
         for (int i = 0; i < LANES; i++) mdl_mem[kind][row][i] = ref_clip(lane_v[i]);
         all = 1'b1;
         for (int k = 0; k < 3; k++)
            for (int r = 0; r < NUM_PIXEL; r++) all &= mdl_done[k][r];
         if (all) begin
            exp_a_q.push_back(mdl_pack(0));
            exp_b_q.push_back(mdl_pack(1));
            exp_c_q.push_back(mdl_pack(2));
            exp_dup_q.push_back(mdl_dup);
            for (int k = 0; k < 3; k++)
               for (int r = 0; r < NUM_PIXEL; r++) mdl_done[k][r] = 1'b0;
            mdl_dup = 1'b0;
         end
      end
   endtask

   // ---------------- stimulus helpers (called at negedge) ----------------
   task automatic rand_lanes();
      for (int i = 0; i < LANES; i++) lane_v[i] = int'($urandom_range(0, 65535)) - 32768;
   endtask

   task automatic const_lanes(int v);
      for (int i = 0; i < LANES; i++) lane_v[i] = v;
   endtask

   task automatic drive(int kind, int row);
      bus.in_valid = 1'b1;
      bus.in_kind  = kind[1:0];
      bus.in_row   = row[2:0];
      for (int i = 0; i < LANES; i++) bus.in_data[i*IN_W +: IN_W] = lane_v[i][15:0];
   endtask

   task automatic send_row(int kind, int row);
      bit ok;
      ok = 1'b0;
      drive(kind, row);
      for (int t = 0; t < 200 && !ok; t++) begin
         if (bus.in_ready) begin
            @(posedge clock);
            mdl_accept(kind, row);
            accept_cnt++;
            ok = 1'b1;
         end
         @(negedge clock);
      end
      check1("send_row_accepted", ok, 1'b1);
   endtask

   task automatic shuffle();
      for (int i = ord_q.size() - 1; i > 0; i--) begin
         int j, tmp;
         j = int'($urandom_range(0, i));
         tmp = ord_q[i];
         ord_q[i] = ord_q[j];
         ord_q[j] = tmp;
      end
   endtask

   task automatic fill_order();
      ord_q.delete();
      for (int i = 0; i < 24; i++) ord_q.push_back(i);
      shuffle();
   endtask

   task automatic wait_out_valid(string name);
      for (int t = 0; t < 100 && !bus.out_valid; t++) @(negedge clock);
      check1(name, bus.out_valid, 1'b1);
   endtask

   task automatic handshake(string name);
      bus.out_ready = 1'b1;
      @(negedge clock);
      bus.out_ready = 1'b0;
      check1({name, "_out_valid_drop"}, bus.out_valid, 1'b0);
      check1({name, "_in_ready_back"}, bus.in_ready, 1'b1);
   endtask

   // ---------------- monitor ----------------
   bit seen = 1'b0;
   initial begin
      forever begin
         @(negedge clock);
         if (reset || !bus.out_valid) begin
            seen = 1'b0;
         end else if (!seen) begin
            seen = 1'b1;
            if (exp_a_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL sb_unexpected_out_valid: got out_valid=1 required no pending set");
            end else begin
               check("sb_a_array", bus.a_half_array, exp_a_q.pop_front());
               check("sb_b_array", bus.b_half_array, exp_b_q.pop_front());
               check("sb_c_array", bus.c_half_array, exp_c_q.pop_front());
`ifdef HALF_COLLECT_DUP_ERR_EN
               check1("sb_dup_err", bus.dup_err, exp_dup_q.pop_front());
`else
               void'(exp_dup_q.pop_front());
`endif
            end
         end
      end
   end

   // ---------------- main sequence ----------------
   initial begin
      logic [ARRAY_W-1:0] exp_v, snap_a, snap_b, snap_c;
      bit                 stable;
      int                 last, cnt0;

      bus.in_valid  = 1'b0;
      bus.in_kind   = '0;
      bus.in_row    = '0;
      bus.in_data   = '0;
      bus.out_ready = 1'b0;
      mdl_reset();

      // Reset and idle
      repeat (3) @(negedge clock);
      check1("reset_in_ready_low", bus.in_ready, 1'b0);
      reset = 1'b0;
      @(negedge clock);
      check1("idle_in_ready", bus.in_ready, 1'b1);
      check1("idle_out_valid", bus.out_valid, 1'b0);
      check("idle_a", bus.a_half_array, '0);
      check("idle_b", bus.b_half_array, '0);
      check("idle_c", bus.c_half_array, '0);
`ifdef HALF_COLLECT_DUP_ERR_EN
      check1("idle_dup_err", bus.dup_err, 1'b0);
`endif

      // Rounding / clipping, two-cycle write latency
      rand_lanes();
      lane_v[0] = -100; lane_v[1] = 100; lane_v[2] = 31; lane_v[3] = 32; lane_v[4] = 20000;
      send_row(0, 0);
      bus.in_valid = 1'b0;
      check("round_not_yet_written", ARRAY_W'(bus.a_half_array[39:0]), '0);
      @(negedge clock);
      check("round_clip_bytes", ARRAY_W'(bus.a_half_array[39:0]), ARRAY_W'(40'hFF_01_00_02_00));

      // Full fill with out_ready held low; A row 0 must not be the completing row
      fill_order();
      if (ord_q[23] == 0) begin
         ord_q[23] = ord_q[0];
         ord_q[0]  = 0;
      end
      foreach (ord_q[n]) begin
         const_lanes(ord_q[n] * 64);
         send_row(ord_q[n] / 8, ord_q[n] % 8);
      end
      bus.in_valid = 1'b0;
      wait_out_valid("fill_out_valid");
      check1("fill_in_ready_low", bus.in_ready, 1'b0);
      for (int k = 0; k < 3; k++) begin
         exp_v = '0;
         for (int r = 0; r < NUM_PIXEL; r++)
            for (int i = 0; i < LANES; i++) exp_v[(r*LANES+i)*8 +: 8] = 8'(k*8 + r);
         if (k == 0) check("fill_a_bytes", bus.a_half_array, exp_v);
         if (k == 1) check("fill_b_bytes", bus.b_half_array, exp_v);
         if (k == 2) check("fill_c_bytes", bus.c_half_array, exp_v);
      end
      snap_a = bus.a_half_array;
      snap_b = bus.b_half_array;
      snap_c = bus.c_half_array;
      stable = 1'b1;
      repeat (10) begin
         @(negedge clock);
         stable &= (bus.a_half_array == snap_a) && (bus.b_half_array == snap_b) &&
                   (bus.c_half_array == snap_c) && bus.out_valid && !bus.in_ready;
      end
      check1("fill_stable_10_cycles", stable, 1'b1);
      handshake("fill");

      // Duplicate and discard
      const_lanes(64);
      send_row(0, 3);
      ord_q.delete();
      for (int i = 0; i < 24; i++) if (i != 3) ord_q.push_back(i);
      shuffle();
      last = ord_q.pop_back();
      repeat (5) ord_q.push_back(100);
      ord_q.push_back(200);
      shuffle();
      foreach (ord_q[n]) begin
         if (ord_q[n] == 100) begin
            rand_lanes();
            send_row(3, int'($urandom_range(0, 7)));
         end else if (ord_q[n] == 200) begin
            const_lanes(128);
            send_row(0, 3);
         end else begin
            rand_lanes();
            send_row(ord_q[n] / 8, ord_q[n] % 8);
         end
      end
      bus.in_valid = 1'b0;
      repeat (3) @(negedge clock);
      check1("dup_no_early_out_valid", bus.out_valid, 1'b0);
      rand_lanes();
      send_row(last / 8, last % 8);
      bus.in_valid = 1'b0;
      wait_out_valid("dup_out_valid");
      check("dup_a_row3", ARRAY_W'(bus.a_half_array[3*ROW_W +: ROW_W]), ARRAY_W'({15{8'h02}}));
`ifdef HALF_COLLECT_DUP_ERR_EN
      check1("dup_err_set", bus.dup_err, 1'b1);
`endif
      handshake("dup");
`ifdef HALF_COLLECT_DUP_ERR_EN
      check1("dup_err_cleared", bus.dup_err, 1'b0);
`endif

      // Reset mid-operation
      fill_order();
      for (int n = 0; n < 20; n++) begin
         rand_lanes();
         send_row(ord_q[n] / 8, ord_q[n] % 8);
      end
      bus.in_valid = 1'b0;
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      mdl_reset();
      check("midreset_a_cleared", bus.a_half_array, '0);
      for (int n = 20; n < 24; n++) begin
         rand_lanes();
         send_row(ord_q[n] / 8, ord_q[n] % 8);
      end
      bus.in_valid = 1'b0;
      repeat (3) @(negedge clock);
      check1("midreset_no_out_valid", bus.out_valid, 1'b0);
      for (int n = 0; n < 20; n++) begin
         rand_lanes();
         send_row(ord_q[n] / 8, ord_q[n] % 8);
      end
      bus.in_valid = 1'b0;
      wait_out_valid("midreset_out_valid");
      handshake("midreset");

      // Backpressure: in_valid never drops
      fill_order();
      cnt0 = accept_cnt;
      foreach (ord_q[n]) begin
         rand_lanes();
         send_row(ord_q[n] / 8, ord_q[n] % 8);
      end
      rand_lanes();
      drive(1, 5);
      wait_out_valid("bp_out_valid");
      stable = 1'b1;
      repeat (5) begin
         @(negedge clock);
         stable &= !bus.in_ready;
      end
      check1("bp_held_off", stable, 1'b1);
      check("bp_accept_count", ARRAY_W'(accept_cnt - cnt0), ARRAY_W'(24));
      handshake("bp");
      send_row(1, 5);
      bus.in_valid = 1'b0;

      repeat (3) @(negedge clock);
      check("sb_queue_drained", ARRAY_W'(exp_a_q.size()), '0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
